// File: rtl/alu_bist_driver.sv
// Exhaustive self-test driver for the 4-bit ALU: sweeps every {op_code, A, B} vector and checks C against a reference model.
// Optional first-failure capture outputs are enabled by defining ALU_BIST_FAIL_LOG_EN.
module alu_bist_driver #(
    parameter int DATA_W  = 4,
    parameter int RES_W   = 6,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [1:0]        op_code,
    input  logic [RES_W-1:0]  C,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count
`ifdef ALU_BIST_FAIL_LOG_EN
    ,
    output logic                first_fail_valid,
    output logic [2*DATA_W+1:0] first_fail_vec,
    output logic [RES_W-1:0]    first_fail_c
`endif
);

    localparam int VEC_W = 2 * DATA_W + 2;
    localparam logic [VEC_W-1:0] VEC_LAST  = {VEC_W{1'b1}};
    localparam logic [VEC_W-1:0] VEC_ONE   = VEC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       WAIT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    logic [VEC_W-1:0]   vec_r;
    logic [3:0]         wait_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   pass_count_r;
    logic [CNT_W-1:0]   fail_count_r;
    logic [RES_W-1:0]   expected_s;
    logic               match_s;
`ifdef ALU_BIST_FAIL_LOG_EN
    logic               first_fail_valid_r;
    logic [VEC_W-1:0]   first_fail_vec_r;
    logic [RES_W-1:0]   first_fail_c_r;
`endif

    // Subtraction wraps naturally in RES_W bits, giving the two's complement result.
    function automatic logic [RES_W-1:0] ref_result(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [RES_W-1:0] a_ext;
        logic [RES_W-1:0] b_ext;
        a_ext = {{(RES_W-DATA_W){1'b0}}, a};
        b_ext = {{(RES_W-DATA_W){1'b0}}, b};
        case (op)
            2'b00:   ref_result = a_ext + b_ext;
            2'b01:   ref_result = a_ext - b_ext;
            2'b10:   ref_result = a_ext & b_ext;
            2'b11:   ref_result = a_ext | b_ext;
            default: ref_result = {RES_W{1'b0}};
        endcase
    endfunction

    // Expected result for the vector currently on the operand bus; X/Z on C never matches.
    always_comb begin
        expected_s = ref_result(vec_r[VEC_W-1:2*DATA_W], vec_r[2*DATA_W-1:DATA_W], vec_r[DATA_W-1:0]);
        match_s    = (C === expected_s);
    end

    // Sweep sequencer: operands come straight from the vector register, so they change on the edge entering DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            vec_r        <= {VEC_W{1'b0}};
            wait_r       <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_count_r <= {CNT_W{1'b0}};
            fail_count_r <= {CNT_W{1'b0}};
`ifdef ALU_BIST_FAIL_LOG_EN
            first_fail_valid_r <= 1'b0;
            first_fail_vec_r   <= {VEC_W{1'b0}};
            first_fail_c_r     <= {RES_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r      <= ST_DRIVE;
                        vec_r        <= {VEC_W{1'b0}};
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        pass_count_r <= {CNT_W{1'b0}};
                        fail_count_r <= {CNT_W{1'b0}};
`ifdef ALU_BIST_FAIL_LOG_EN
                        first_fail_valid_r <= 1'b0;
                        first_fail_vec_r   <= {VEC_W{1'b0}};
                        first_fail_c_r     <= {RES_W{1'b0}};
`endif
                    end
                end
                ST_DRIVE: begin
                    wait_r  <= WAIT_LOAD;
                    state_r <= (LATENCY == 1) ? ST_CHECK : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_r <= 4'd1) begin
                        wait_r  <= 4'd0;
                        state_r <= ST_CHECK;
                    end else begin
                        wait_r <= wait_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (match_s) begin
                        pass_count_r <= pass_count_r + CNT_ONE;
                    end else begin
                        fail_count_r <= fail_count_r + CNT_ONE;
`ifdef ALU_BIST_FAIL_LOG_EN
                        if (!first_fail_valid_r) begin
                            first_fail_valid_r <= 1'b1;
                            first_fail_vec_r   <= vec_r;
                            first_fail_c_r     <= C;
                        end
`endif
                    end
                    if (vec_r == VEC_LAST) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        vec_r   <= vec_r + VEC_ONE;
                        state_r <= ST_DRIVE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign op_code    = vec_r[VEC_W-1:2*DATA_W];
    assign A          = vec_r[2*DATA_W-1:DATA_W];
    assign B          = vec_r[DATA_W-1:0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass_count = pass_count_r;
    assign fail_count = fail_count_r;
`ifdef ALU_BIST_FAIL_LOG_EN
    assign first_fail_valid = first_fail_valid_r;
    assign first_fail_vec   = first_fail_vec_r;
    assign first_fail_c     = first_fail_c_r;
`endif

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: bench-side ALUs (1-cycle with fault modes, 3-stage pipeline) and a result scoreboard.
module tb_alu_bist_driver;

    logic       clk;
    logic       rst;
    logic       start1, start2, start3;
    logic [3:0] a1, b1, a2, b2, a3, b3;
    logic [1:0] op1, op2, op3;
    logic [5:0] c1, c2, c3;
    logic       busy1, busy2, busy3;
    logic       done1, done2, done3;
    logic [10:0] pass1, fail1, pass2, fail2, pass3, fail3;
`ifdef ALU_BIST_FAIL_LOG_EN
    logic       ffv1, ffv2, ffv3;
    logic [9:0] ffvec1, ffvec2, ffvec3;
    logic [5:0] ffc1, ffc2, ffc3;
`endif

    int alu_mode;
    int n_cmp;
    int n_fail;
    logic [5:0] p2a, p2b, p3a, p3b;

    typedef struct {
        logic [10:0] pass;
        logic [10:0] fail;
        logic        ff_valid;
        logic [9:0]  ff_vec;
        logic [5:0]  ff_c;
    } exp_t;

    exp_t       sb_q[$];
    logic [9:0] vq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: correct ALU. Mode 1: op=10 returns ~(A&B). Mode 2: op=01,A=0,B=F returns 6'b010001.
    function automatic logic [5:0] bench_alu(input logic [1:0] op, input logic [3:0] a,
                                             input logic [3:0] b, input int mode);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        bench_alu = r[5:0];
        if (mode == 1 && op == 2'd2) bench_alu = {2'b00, ~(a & b)};
        if (mode == 2 && op == 2'd1 && a == 4'd0 && b == 4'd15) bench_alu = 6'b010001;
    endfunction

    always @(posedge clk) c1 <= bench_alu(op1, a1, b1, alu_mode);

    always @(posedge clk) begin
        p2a <= bench_alu(op2, a2, b2, 0);
        p2b <= p2a;
        c2  <= p2b;
        p3a <= bench_alu(op3, a3, b3, 0);
        p3b <= p3a;
        c3  <= p3b;
    end

    alu_bist_driver #(.DATA_W(4), .RES_W(6), .LATENCY(1), .CNT_W(11)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .op_code(op1), .C(c1),
        .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1)
`ifdef ALU_BIST_FAIL_LOG_EN
        , .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_c(ffc1)
`endif
    );

    alu_bist_driver #(.DATA_W(4), .RES_W(6), .LATENCY(2), .CNT_W(11)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .op_code(op2), .C(c2),
        .busy(busy2), .done(done2), .pass_count(pass2), .fail_count(fail2)
`ifdef ALU_BIST_FAIL_LOG_EN
        , .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .first_fail_c(ffc2)
`endif
    );

    alu_bist_driver #(.DATA_W(4), .RES_W(6), .LATENCY(3), .CNT_W(11)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .op_code(op3), .C(c3),
        .busy(busy3), .done(done3), .pass_count(pass3), .fail_count(fail3)
`ifdef ALU_BIST_FAIL_LOG_EN
        , .first_fail_valid(ffv3), .first_fail_vec(ffvec3), .first_fail_c(ffc3)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({op1, a1, b1} !== 10'd0) begin
            n_fail++; $display("FAIL reset_operands: got %h want 000", {op1, a1, b1});
        end
        n_cmp++;
        if ({busy1, done1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_done: got %b want 00", {busy1, done1});
        end
        n_cmp++;
        if ({pass1, fail1} !== 22'd0) begin
            n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", pass1, fail1);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy1, done1, busy2, busy3} !== 4'b0000) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {busy1, done1, busy2, busy3});
        end
    endtask

    // One full dut1 sweep: pushes the expected vector order and final counts, then checks them as the DUT runs.
    task automatic do_sweep1(input string name, input int restart_vec);
        exp_t       e;
        logic [9:0] v;
        logic [9:0] held;
        logic [9:0] obs;
        logic [5:0] got, want;
        int         cyc;
        bit         seq_bad;
        e.pass = 11'd0; e.fail = 11'd0; e.ff_valid = 1'b0; e.ff_vec = 10'd0; e.ff_c = 6'd0;
        for (int i = 0; i < 1024; i++) begin
            v    = i[9:0];
            got  = bench_alu(v[9:8], v[7:4], v[3:0], alu_mode);
            want = bench_alu(v[9:8], v[7:4], v[3:0], 0);
            if (got == want) begin
                e.pass = e.pass + 11'd1;
            end else begin
                e.fail = e.fail + 11'd1;
                if (!e.ff_valid) begin
                    e.ff_valid = 1'b1; e.ff_vec = v; e.ff_c = got;
                end
            end
            vq.push_back(v);
        end
        sb_q.push_back(e);

        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        n_cmp++;
        if (done1 !== 1'b0) begin
            n_fail++; $display("FAIL %s done_clear: got %b want 0", name, done1);
        end
        cyc = 0; seq_bad = 1'b0; held = 10'd0;
        while (busy1 === 1'b1 && cyc < 3000) begin
            obs = {op1, a1, b1};
            if (cyc % 2 == 0) held = (vq.size() > 0) ? vq.pop_front() : 10'h3FF;
            if (!seq_bad) begin
                n_cmp++;
                if (obs !== held) begin
                    n_fail++; seq_bad = 1'b1;
                    $display("FAIL %s operand_seq cycle %0d: got %h want %h", name, cyc, obs, held);
                end
            end
            start1 = (restart_vec >= 0 && cyc == 2 * restart_vec) ? 1'b1 : 1'b0;
            cyc++;
            @(negedge clk);
        end
        start1 = 1'b0;
        n_cmp++;
        if (cyc != 2048) begin
            n_fail++; $display("FAIL %s busy_cycles: got %0d want 2048", name, cyc);
        end
        n_cmp++;
        if (vq.size() != 0) begin
            n_fail++; $display("FAIL %s vectors_left: got %0d want 0", name, vq.size());
        end
        vq.delete();
        e = sb_q.pop_front();
        n_cmp++;
        if (done1 !== 1'b1) begin
            n_fail++; $display("FAIL %s done: got %b want 1", name, done1);
        end
        n_cmp++;
        if (pass1 !== e.pass || fail1 !== e.fail) begin
            n_fail++; $display("FAIL %s counts: got %0d/%0d want %0d/%0d", name, pass1, fail1, e.pass, e.fail);
        end
`ifdef ALU_BIST_FAIL_LOG_EN
        n_cmp++;
        if (ffv1 !== e.ff_valid || (e.ff_valid && (ffvec1 !== e.ff_vec || ffc1 !== e.ff_c))) begin
            n_fail++;
            $display("FAIL %s first_fail: got %b/%h/%b want %b/%h/%b", name, ffv1, ffvec1, ffc1,
                     e.ff_valid, e.ff_vec, e.ff_c);
        end
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== e.pass || {op1, a1, b1} !== 10'h3FF) begin
            n_fail++;
            $display("FAIL %s done_hold: got done=%b busy=%b pass=%0d ops=%h want 1/0/%0d/3ff",
                     name, done1, busy1, pass1, {op1, a1, b1}, e.pass);
        end
    endtask

    task automatic test_full_sweep();
        alu_mode = 0;
        do_sweep1("full_sweep", -1);
    endtask

    task automatic test_corrupt_and();
        alu_mode = 1;
        do_sweep1("corrupt_and", -1);
        alu_mode = 0;
    endtask

    task automatic test_sub_boundary();
        alu_mode = 2;
        do_sweep1("sub_boundary", -1);
        alu_mode = 0;
    endtask

    task automatic test_start_while_busy();
        alu_mode = 0;
        do_sweep1("start_while_busy", 500);
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        alu_mode = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        cyc = 0;
        while (cyc < 200 && busy1 === 1'b1) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if ({op1, a1, b1} !== 10'd100 || pass1 !== 11'd100) begin
            n_fail++; $display("FAIL mid_sweep_position: got ops=%h pass=%0d want 064/100", {op1, a1, b1}, pass1);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({op1, a1, b1} !== 10'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 11'd0 || fail1 !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got ops=%h busy=%b done=%b cnt=%0d/%0d want 000/0/0/0/0",
                     {op1, a1, b1}, busy1, done1, pass1, fail1);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        do_sweep1("after_reset", -1);
    endtask

    task automatic test_latency();
        int cyc, n2, n3;
        @(negedge clk); start2 = 1'b1; start3 = 1'b1;
        @(negedge clk); start2 = 1'b0; start3 = 1'b0;
        cyc = 0; n2 = 0; n3 = 0;
        while ((busy2 === 1'b1 || busy3 === 1'b1) && cyc < 6000) begin
            if (busy2 === 1'b1) n2++;
            if (busy3 === 1'b1) n3++;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (n3 != 4096 || done3 !== 1'b1) begin
            n_fail++; $display("FAIL lat3_busy: got %0d cycles done=%b want 4096/1", n3, done3);
        end
        n_cmp++;
        if (pass3 !== 11'd1024 || fail3 !== 11'd0) begin
            n_fail++; $display("FAIL lat3_counts: got %0d/%0d want 1024/0", pass3, fail3);
        end
        n_cmp++;
        if (n2 != 3072 || done2 !== 1'b1) begin
            n_fail++; $display("FAIL lat2_busy: got %0d cycles done=%b want 3072/1", n2, done2);
        end
        n_cmp++;
        if (!(fail2 > 11'd0) || (pass2 + fail2) !== 11'd1024) begin
            n_fail++; $display("FAIL lat2_counts: got %0d/%0d want fail>0 and sum 1024", pass2, fail2);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; alu_mode = 0;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        test_reset();
        test_full_sweep();
        test_corrupt_and();
        test_sub_boundary();
        test_start_while_busy();
        test_reset_mid_sweep();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_bist_driver.md
Name: alu_bist_driver

Overview:
- Hardware stimulus generator and result checker for the 4-bit ALU: it drives operands and opcode, samples the ALU result, and counts pass/fail.
- Lets the ALU be self-tested on silicon/FPGA without a software bench.
- Sits beside the ALU; its A/B/op_code outputs connect to the ALU inputs, and the ALU C output returns to it.
- Sweeps all 1024 {op_code, A, B} combinations exhaustively against an internal reference model.

Parameters:
- DATA_W, 4, operand width of A and B
- RES_W, 6, ALU result width (signed)
- LATENCY, 1, clock cycles from an operand change on A/B/op_code to a valid C; legal range 1..15
- CNT_W, 11, width of pass/fail counters (holds 0..1024)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle pulse that begins a sweep
- A  output  DATA_W  operand A to ALU
- B  output  DATA_W  operand B to ALU
- op_code  output  2  opcode to ALU
- C  input  RES_W  signed ALU result
- busy  output  1  high while a sweep is running
- done  output  1  high after a sweep completes; held until the next accepted start or rst
- pass_count  output  CNT_W  number of matching vectors
- fail_count  output  CNT_W  number of mismatching vectors

Behaviour:
- Reset (async, rst=1): state IDLE; A=0, B=0, op_code=0, busy=0, done=0, pass_count=0, fail_count=0, vector index=0, wait counter=0.
- Vector index: 10 bits, ordered {op_code, A, B}; B varies fastest. Index 0 is op=00, A=0, B=0. Index 1023 is op=11, A=F, B=F.
- Reference model. All results are 6-bit two's complement:
  - 00: A+B, zero-extended (max 30).
  - 01: A-B, signed, so 0-15 = -15 = 6'b110001.
  - 10: A&B, zero-extended.
  - 11: A|B, zero-extended.
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE → DRIVE:
  - Taken on start=1.
  - On this transition: counters clear, index=0, busy=1, done=0.
- DRIVE (1 cycle):
  - A/B/op_code are registered from the index; they change on the edge entering DRIVE.
  - The wait counter loads LATENCY-1.
- WAIT:
  - Decrements each cycle; when it reaches 0, go to CHECK.
  - With LATENCY=1, WAIT lasts 0 cycles and DRIVE goes directly to CHECK.
- CHECK (1 cycle):
  - Compares C with the expected value for the current vector.
  - Increments pass_count on a match, otherwise fail_count.
  - If index=1023, go to DONE; else index+1 and go to DRIVE.
- Sampling rule: C is sampled exactly LATENCY+1 cycles after the operands changed. Each vector occupies LATENCY+1 cycles from DRIVE through CHECK.
- A full sweep takes 1024×(LATENCY+1) cycles from the first DRIVE cycle to the edge entering DONE.
- DONE:
  - busy=0, done=1; counters and operands hold.
  - start=1 restarts the sweep (same actions as from IDLE).
- start while busy: ignored; the sweep is not disturbed.
- Reset mid-sweep: all outputs return to their reset values immediately (async). A new start after reset runs a full 1024-vector sweep.
- Counters never wrap; the maximum is 1024, and pass_count + fail_count = 1024 at done.
- X/Z on C counts as a mismatch (case-equality compare).

Optional Feature:
- Macro: ALU_BIST_FAIL_LOG_EN
- When defined, three extra outputs are present:
  - first_fail_valid (1 bit)
  - first_fail_vec (10 bits, {op_code, A, B})
  - first_fail_c (RES_W bits, the sampled C)
- These capture the first mismatching vector of a sweep; they clear on rst and on an accepted start, and hold afterwards.
- When not defined, these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Bench ALU model correct, LATENCY=1, one start pulse → busy for 2048 cycles; done=1; pass_count=1024, fail_count=0.
- Bench ALU corrupts the result for op=10 (returns ~(A&B) truncated) → pass_count=768, fail_count=256. With ALU_BIST_FAIL_LOG_EN: first_fail_vec=10'b10_0000_0000, first_fail_c=6'b001111.
- Bench ALU with 3-cycle pipeline, LATENCY=3 → pass_count=1024. The same ALU with LATENCY=2 → fail_count>0.
- Pulse start again at vector 500 mid-sweep → ignored; final counts identical to an uninterrupted run (1024/0).
- Assert rst for 1 cycle at vector 100 → A=B=op_code=0, busy=0, counters=0 within the same cycle. A subsequent start gives 1024/0.
- Check op=01, A=0, B=F → expected C=6'b110001 is counted as a pass. A bench ALU returning 6'b010001 for that vector → fail_count=1.
